// File: rtl/ones_mod_detector.sv
// Counts qualifying serial bits modulo MOD, flags multiples of MOD and grades each frame.
// One-cycle latency on all registered outputs; no backpressure (every valid bit is consumed).
module ones_mod_detector #(
  parameter  int MOD = 4,
  parameter  int PW  = 16,
  localparam int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          din_valid,
  input  logic          din,
  input  logic          count_zeros,
  input  logic          frame_end,
  output logic [CW-1:0] count,
  output logic          detected,
  output logic          wrap_pulse,
  output logic          result_valid,
  output logic          result_pass,
  output logic [PW-1:0] pass_frames
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  logic [CW-1:0] count_q, count_d, next_cnt;
  logic          wrap_q, wrap_d;
  logic          rv_q, rv_d;
  logic          rp_q, rp_d;
  logic [PW-1:0] pf_q, pf_d;
  logic          qual;
  logic          at_last;

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    rv_d     = 1'b0;
    rp_d     = rp_q;
    pf_d     = pf_q;
    qual     = din_valid & (din ^ count_zeros);
    // Explicit compare against MOD-1 so non-power-of-2 moduli wrap correctly.
    at_last  = (count_q == LAST);
    next_cnt = count_q;
    if (qual) begin
      next_cnt = at_last ? '0 : count_q + CW'(1);
    end

    if (clear) begin
      count_d = '0;
    end else if (din_valid) begin
      wrap_d = qual & at_last;
      if (frame_end) begin
        count_d = '0;
        rv_d    = 1'b1;
        rp_d    = (next_cnt == '0);
        if ((next_cnt == '0) && (pf_q != '1)) begin
          pf_d = pf_q + PW'(1);
        end
      end else begin
        count_d = next_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      rv_q    <= 1'b0;
      rp_q    <= 1'b0;
      pf_q    <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      rv_q    <= rv_d;
      rp_q    <= rp_d;
      pf_q    <= pf_d;
    end
  end

  assign count        = count_q;
  assign detected     = (count_q == '0);
  assign wrap_pulse   = wrap_q;
  assign result_valid = rv_q;
  assign result_pass  = rp_q;
  assign pass_frames  = pf_q;

endmodule

// File: tb/tb_ones_mod_detector.sv
// Directed bench: MOD=4 vector table plus hand sequences on MOD=5, MOD=3 and a PW=2 instance.
module tb_ones_mod_detector;

  logic clk;
  logic reset, clear, din_valid, din, count_zeros, frame_end;

  logic [1:0]  c4;  logic d4, w4, rv4, rp4;  logic [15:0] pf4;
  logic [2:0]  c5;  logic d5, w5, rv5, rp5;  logic [15:0] pf5;
  logic [1:0]  c3;  logic d3, w3, rv3, rp3;  logic [15:0] pf3;
  logic [1:0]  cs;  logic ds, ws, rvs, rps;  logic [1:0]  pfs;

  ones_mod_detector #(.MOD(4), .PW(16)) u4 (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
    .count_zeros(count_zeros), .frame_end(frame_end), .count(c4), .detected(d4),
    .wrap_pulse(w4), .result_valid(rv4), .result_pass(rp4), .pass_frames(pf4));

  ones_mod_detector #(.MOD(5), .PW(16)) u5 (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
    .count_zeros(count_zeros), .frame_end(frame_end), .count(c5), .detected(d5),
    .wrap_pulse(w5), .result_valid(rv5), .result_pass(rp5), .pass_frames(pf5));

  ones_mod_detector #(.MOD(3), .PW(16)) u3 (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
    .count_zeros(count_zeros), .frame_end(frame_end), .count(c3), .detected(d3),
    .wrap_pulse(w3), .result_valid(rv3), .result_pass(rp3), .pass_frames(pf3));

  ones_mod_detector #(.MOD(4), .PW(2)) us (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
    .count_zeros(count_zeros), .frame_end(frame_end), .count(cs), .detected(ds),
    .wrap_pulse(ws), .result_valid(rvs), .result_pass(rps), .pass_frames(pfs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic vld, d, cz, fe, clr;
    int   cnt;
    logic det, wrap, rv, rp;
    int   pf;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic v, input logic b, input logic cz, input logic fe, input logic clr);
    @(negedge clk);
    reset = 1'b1; din_valid = v; din = b; count_zeros = cz; frame_end = fe; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; din_valid = 1'b0; din = 1'b0; count_zeros = 1'b0; frame_end = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // vld d cz fe clr | cnt det wrap rv rp pf   (MOD=4)
    tbl[0]  = '{1,1,0,0,0, 1,0,0,0,0, 0};
    tbl[1]  = '{1,1,0,0,0, 2,0,0,0,0, 0};
    tbl[2]  = '{1,1,0,0,0, 3,0,0,0,0, 0};
    tbl[3]  = '{1,1,0,0,0, 0,1,1,0,0, 0};
    tbl[4]  = '{1,1,0,0,0, 1,0,0,0,0, 0};
    tbl[5]  = '{1,1,0,0,0, 2,0,0,0,0, 0};
    tbl[6]  = '{1,1,0,0,0, 3,0,0,0,0, 0};
    tbl[7]  = '{1,1,0,0,0, 0,1,1,0,0, 0};
    tbl[8]  = '{0,1,0,0,0, 0,1,0,0,0, 0};
    tbl[9]  = '{1,0,0,0,0, 0,1,0,0,0, 0};
    tbl[10] = '{1,0,1,0,0, 1,0,0,0,0, 0};
    tbl[11] = '{1,1,1,0,0, 1,0,0,0,0, 0};
    tbl[12] = '{1,1,0,1,0, 0,1,0,1,0, 0};
    tbl[13] = '{0,0,0,0,0, 0,1,0,0,0, 0};
    tbl[14] = '{1,0,0,1,0, 0,1,0,1,1, 1};
    tbl[15] = '{0,0,0,0,0, 0,1,0,0,1, 1};

    reset = 1'b0; clear = 1'b0; din_valid = 1'b0; din = 1'b0; count_zeros = 1'b0; frame_end = 1'b0;
    do_reset();
    check("rst count", c4, 0);
    check("rst detected", d4, 1);
    check("rst wrap", w4, 0);
    check("rst rv", rv4, 0);
    check("rst rp", rp4, 0);
    check("rst pf", pf4, 0);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].vld, tbl[i].d, tbl[i].cz, tbl[i].fe, tbl[i].clr);
      check($sformatf("tbl%0d count", i), c4, tbl[i].cnt);
      check($sformatf("tbl%0d det", i), d4, tbl[i].det);
      check($sformatf("tbl%0d wrap", i), w4, tbl[i].wrap);
      check($sformatf("tbl%0d rv", i), rv4, tbl[i].rv);
      check($sformatf("tbl%0d rp", i), rp4, tbl[i].rp);
      check($sformatf("tbl%0d pf", i), pf4, tbl[i].pf);
    end

    // Modulus-5 instance: 1,0,1,1,0,1,1 closing on the wrap
    do_reset();
    begin
      logic [6:0] bits5;
      int exp5 [6];
      bits5 = 7'b1101101;
      exp5 = '{1,1,2,3,3,4};
      for (int i = 0; i < 6; i++) begin
        apply(1'b1, bits5[i], 1'b0, 1'b0, 1'b0);
        check($sformatf("m5 count%0d", i), c5, exp5[i]);
      end
      apply(1'b1, bits5[6], 1'b0, 1'b1, 1'b0);
      check("m5 end count", c5, 0);
      check("m5 end wrap", w5, 1);
      check("m5 end rv", rv5, 1);
      check("m5 end rp", rp5, 1);
      check("m5 end pf", pf5, 1);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("m5 rv pulse ends", rv5, 0);
      check("m5 rp held", rp5, 1);
    end

    // Modulus-3 instance in zeros mode: 0,0,1,0 closing on the wrap
    do_reset();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("m3 count0", c3, 1);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("m3 count1", c3, 2);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("m3 count2", c3, 2);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("m3 end count", c3, 0);
    check("m3 end wrap", w3, 1);
    check("m3 end rv", rv3, 1);
    check("m3 end rp", rp3, 1);

    // Bubbles and clear on MOD=4, with one passing frame banked first
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("empty frame rp", rp4, 1);
    check("empty frame pf", pf4, 1);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre bubble count", c4, 2);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("bubble%0d count", i), c4, 2);
      check($sformatf("bubble%0d rv", i), rv4, 0);
    end
    apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clear count", c4, 0);
    check("clear rv", rv4, 0);
    check("clear pf", pf4, 1);
    check("clear rp held", rp4, 1);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre clr-wrap count", c4, 3);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr-wrap count", c4, 0);
    check("clr-wrap wrap", w4, 0);

    // Reset mid-frame abandons the frame and zeroes the statistics
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst pre count", c4, 3);
    do_reset();
    check("midrst count", c4, 0);
    check("midrst det", d4, 1);
    check("midrst rv", rv4, 0);
    check("midrst rp", rp4, 0);
    check("midrst pf", pf4, 0);
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 1'b0, (i == 3), 1'b0);
    check("midrst frame rv", rv4, 1);
    check("midrst frame rp", rp4, 1);
    check("midrst frame pf", pf4, 1);

    // PW=2 saturation over five passing frames
    do_reset();
    begin
      int exps [5];
      exps = '{1,2,3,3,3};
      for (int f = 0; f < 5; f++) begin
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 1'b0, (i == 3), 1'b0);
        check($sformatf("sat pf%0d", f), pfs, exps[f]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
